recursive_mux_tree: RTL and testbench



---
 rtl/recursive_mux_tree_pkg.sv | 16 +
 rtl/recursive_mux_tree_node.sv | 39 +++
 rtl/recursive_mux_tree.sv | 116 +++++++++++
 tb/tb_recursive_mux_tree.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/recursive_mux_tree_pkg.sv
// Shared helpers for the recursive_mux_tree selector.
// Optional build macro: RECURSIVE_MUX_TREE_PIPE_EN (adds one register per tree level).
package recursive_mux_tree_pkg;

    // The select port always has at least one bit, even for a single-input tree.
    function automatic int sel_width(input int a);
        return (a < 1) ? 1 : a;
    endfunction

    // Offset of the first word of tree level l in the flat word array of a tree
    // with n leaves: level 0 holds the n leaves, level l holds n >> l words.
    function automatic int level_base(input int n, input int l);
        return 2 * n - ((2 * n) >> l);
    endfunction

endpackage

// File: rtl/recursive_mux_tree_node.sv
// Single 2:1 node of the recursive mux tree.
// With RECURSIVE_MUX_TREE_PIPE_EN defined the node output is registered;
// otherwise the node is purely combinational and the clock/reset are unused.
module recursive_mux_tree_node #(
    parameter int W = 14
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         sel,
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    output logic [W-1:0] out
);

    logic [W-1:0] out_d;

    // Pick the upper input when sel is set, the lower input otherwise.
    always_comb begin
        out_d = sel ? in1 : in0;
    end

`ifdef RECURSIVE_MUX_TREE_PIPE_EN
    logic [W-1:0] out_q;

    // Pipeline register after this tree level; cleared asynchronously.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;
`else
    assign out = out_d;
`endif

endmodule

// File: rtl/recursive_mux_tree.sv
// Registered 2^A-to-1 selector of W-bit words built as a binary tree of 2:1 nodes.
// Level l of the tree consumes select[l]; the last level picks lower or upper half.
// Optional build macro: RECURSIVE_MUX_TREE_PIPE_EN
//   undefined: combinational tree + one output register (latency 1)
//   defined  : a register after every level, select bits delayed alongside the
//              data so each word meets its own select (latency max(A,1)).
module recursive_mux_tree
    import recursive_mux_tree_pkg::*;
#(
    parameter int A = 3,
    parameter int W = 14
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [sel_width(A)-1:0] select,
    input  logic [W-1:0]            data_in [(1<<A)-1:0],
    output logic [W-1:0]            data_out
);

    localparam int N     = 1 << A;
    localparam int SEL_W = sel_width(A);
    localparam int ROOT  = level_base(N, A);

`ifdef RECURSIVE_MUX_TREE_PIPE_EN
    // The last node level already registers; only a leaf-only tree needs a flop.
    localparam bit OUT_REG = (A == 0);
`else
    localparam bit OUT_REG = 1'b1;
`endif

    // Flat storage of every tree level: leaves first, root last.
    logic [W-1:0]     tree [2*N-1];
    // Select bit seen by each level, already aligned with that level's data.
    logic [SEL_W-1:0] lvl_sel;

    for (genvar i = 0; i < N; i++) begin : g_leaf
        assign tree[i] = data_in[i];
    end

`ifdef RECURSIVE_MUX_TREE_PIPE_EN
    if (A == 0) begin : g_sel_none
        assign lvl_sel = select;
    end else begin : g_sel_pipe
        // Bit b is consumed by level b, so it travels through b delay stages.
        for (genvar b = 0; b < A; b++) begin : g_bit
            logic [b:0] tap;
            assign tap[0] = select[b];
            if (b > 0) begin : g_dly
                logic [b:1] dly_d;
                logic [b:1] dly_q;

                // Shift the select bit one stage further each cycle.
                always_comb begin
                    dly_d = tap[b-1:0];
                end

                // Select delay line registers, cleared with the data pipeline.
                always_ff @(posedge aclk or negedge aresetn) begin
                    if (!aresetn) begin
                        dly_q <= '0;
                    end else begin
                        dly_q <= dly_d;
                    end
                end

                assign tap[b:1] = dly_q;
            end
            assign lvl_sel[b] = tap[b];
        end
    end
`else
    assign lvl_sel = select;
`endif

    // Level l reduces word pairs (2i, 2i+1) of level l into word i of level l+1.
    for (genvar l = 0; l < A; l++) begin : g_lvl
        localparam int IN_BASE  = level_base(N, l);
        localparam int OUT_BASE = level_base(N, l + 1);
        for (genvar i = 0; i < (N >> (l + 1)); i++) begin : g_node
            recursive_mux_tree_node #(
                .W(W)
            ) u_node (
                .aclk    (aclk),
                .aresetn (aresetn),
                .sel     (lvl_sel[l]),
                .in0     (tree[IN_BASE + 2*i]),
                .in1     (tree[IN_BASE + 2*i + 1]),
                .out     (tree[OUT_BASE + i])
            );
        end
    end

    if (OUT_REG) begin : g_out_reg
        logic [W-1:0] data_out_d;
        logic [W-1:0] data_out_q;

        // Root of the tree feeds the output register.
        always_comb begin
            data_out_d = tree[ROOT];
        end

        // Output register, cleared asynchronously.
        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                data_out_q <= '0;
            end else begin
                data_out_q <= data_out_d;
            end
        end

        assign data_out = data_out_q;
    end else begin : g_out_wire
        assign data_out = tree[ROOT];
    end

endmodule

// File: tb/tb_recursive_mux_tree.sv
// Self-checking bench for recursive_mux_tree (default build or with
// RECURSIVE_MUX_TREE_PIPE_EN defined). Four instances cover A=3/W=16, A=3/W=14,
// A=0/W=8 and A=4/W=14.
module tb_recursive_mux_tree;

`ifdef RECURSIVE_MUX_TREE_PIPE_EN
    localparam int LAT3 = 3;
    localparam int LAT4 = 4;
`else
    localparam int LAT3 = 1;
    localparam int LAT4 = 1;
`endif

    // ---------------- clock / reset ----------------
    logic aclk;
    logic aresetn;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // ---------------- DUT signals ----------------
    logic [2:0]  sel16;
    logic [15:0] d16 [7:0];
    logic [15:0] out16;

    logic [2:0]  sel14;
    logic [13:0] d14 [7:0];
    logic [13:0] out14;

    logic [0:0]  sel0;
    logic [7:0]  d0 [0:0];
    logic [7:0]  out0;

    logic [3:0]  sel4;
    logic [13:0] d4 [15:0];
    logic [13:0] out4;

    recursive_mux_tree #(.A(3), .W(16)) u_a3w16 (
        .aclk(aclk), .aresetn(aresetn), .select(sel16), .data_in(d16), .data_out(out16));
    recursive_mux_tree #(.A(3), .W(14)) u_a3w14 (
        .aclk(aclk), .aresetn(aresetn), .select(sel14), .data_in(d14), .data_out(out14));
    recursive_mux_tree #(.A(0), .W(8)) u_a0w8 (
        .aclk(aclk), .aresetn(aresetn), .select(sel0), .data_in(d0), .data_out(out0));
    recursive_mux_tree #(.A(4), .W(14)) u_a4w14 (
        .aclk(aclk), .aresetn(aresetn), .select(sel4), .data_in(d4), .data_out(out4));

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  sel;
        logic [13:0] exp;
    } vec_t;

    vec_t cur_tbl[$];

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Stream cur_tbl into the A=3/W=14 instance one select per cycle and
    // compare each result LAT3 edges after it was applied.
    task automatic run_tbl14(input string name);
        logic [13:0] exp_q[$];
        logic [13:0] e;
        exp_q = {};
        foreach (cur_tbl[j]) begin
            sel14 = cur_tbl[j].sel;
            exp_q.push_back(cur_tbl[j].exp);
            tick();
            if (exp_q.size() == LAT3) begin
                e = exp_q.pop_front();
                check(name, {2'b00, out14}, {2'b00, e});
            end
        end
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            check(name, {2'b00, out14}, {2'b00, e});
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [13:0] exp_q[$];
        logic [13:0] e;

        aresetn = 1'b0;
        sel16 = 3'd5; sel14 = 3'd0; sel0 = 1'b0; sel4 = 4'd0;
        for (int i = 0; i < 8; i++) d16[i] = 16'h1000 + 16'(i);
        for (int i = 0; i < 8; i++) d14[i] = 14'(i * 3);
        d0[0] = 8'hA5;
        for (int i = 0; i < 16; i++) d4[i] = 14'(i * 1000 + 7);

        // 1. reset holds every output at zero, then the first result appears
        tick(); tick(); tick();
        check("reset_a3w16", out16, 16'h0000);
        check("reset_a3w14", {2'b00, out14}, 16'h0000);
        check("reset_a0w8",  {8'h00, out0},  16'h0000);
        check("reset_a4w14", {2'b00, out4},  16'h0000);
        aresetn = 1'b1;
        #1;
        check("release_no_edge", out16, 16'h0000);
        for (int k = 0; k < LAT3; k++) tick();
        check("first_after_release", out16, 16'h1005);

        // 2. sweep select 0..7 over data i*3
        cur_tbl = {};
        for (int i = 0; i < 8; i++) cur_tbl.push_back('{sel: 3'(i), exp: 14'(i * 3)});
        run_tbl14("sweep");

        // 3. zero-filled upper entries with a full-scale word at index 5
        d14[7] = 14'h0000;
        d14[6] = 14'h0000;
        d14[5] = 14'h3FFF;
        cur_tbl = {};
        cur_tbl.push_back('{sel: 3'd7, exp: 14'h0000});
        cur_tbl.push_back('{sel: 3'd5, exp: 14'h3FFF});
        cur_tbl.push_back('{sel: 3'd6, exp: 14'h0000});
        cur_tbl.push_back('{sel: 3'd0, exp: 14'h0000});
        cur_tbl.push_back('{sel: 3'd4, exp: 14'h000C});
        cur_tbl.push_back('{sel: 3'd5, exp: 14'h3FFF});
        cur_tbl.push_back('{sel: 3'd1, exp: 14'h0003});
        run_tbl14("zero_fill");

        // 4. single-input tree ignores select
        d0[0] = 8'hA5;
        tick();
        check("a0_pass", {8'h00, out0}, 16'h00A5);
        for (int k = 0; k < 4; k++) begin
            sel0 = ~sel0;
            tick();
            check("a0_sel_toggle", {8'h00, out0}, 16'h00A5);
        end
        d0[0] = 8'h5A;
        tick();
        check("a0_new_data", {8'h00, out0}, 16'h005A);

        // 5. asynchronous reset in the middle of a stream
        for (int i = 0; i < 8; i++) d14[i] = 14'(i * 3);
        sel14 = 3'd7;
        for (int k = 0; k < LAT3; k++) tick();
        check("pre_async", {2'b00, out14}, 16'h0015);
        #2;
        aresetn = 1'b0;
        #1;
        check("async_clear", {2'b00, out14}, 16'h0000);
        tick();
        check("reset_held_1", {2'b00, out14}, 16'h0000);
        tick();
        check("reset_held_2", {2'b00, out14}, 16'h0000);
        aresetn = 1'b1;
        #1;
        check("released_no_edge", {2'b00, out14}, 16'h0000);
        for (int k = 1; k < LAT3; k++) begin
            tick();
            check("refill_zero", {2'b00, out14}, 16'h0000);
        end
        tick();
        check("after_release", {2'b00, out14}, 16'h0015);

        // 6. random select and data on the A=4 tree against a delayed reference
        exp_q = {};
        for (int c = 0; c < 1000; c++) begin
            sel4 = 4'($urandom_range(0, 15));
            for (int i = 0; i < 16; i++) d4[i] = 14'($urandom_range(0, 16383));
            exp_q.push_back(d4[sel4]);
            tick();
            if (exp_q.size() == LAT4) begin
                e = exp_q.pop_front();
                check("random_a4", {2'b00, out4}, {2'b00, e});
            end
        end
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            check("random_a4_flush", {2'b00, out4}, {2'b00, e});
        end

        // ---------------- final report ----------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
